gate_input_debouncer: RTL and testbench
=======================================

// Module: gate_input_debouncer
// PURPOSE
//  Input conditioning stage that sits directly upstream of the two-input logic-gate dataflow block.
//  It takes two raw, asynchronous switch/button inputs and synchronises each to clk, then debounces it.
//  Outputs clean levels a/b that drive the gate block's a/b inputs.
//  Also emits one-cycle edge pulses and a settled flag for the LED/capture logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive clk edges a changed input must hold before the output follows; legal >= 2
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  localparam, counter width (derived, not overridable)
// PORTS
//  clk       in   1  single system clock, all logic on rising edge
//  rst_n     in   1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk
//  sw_a_in   in   1  raw switch A, asynchronous to clk, may bounce
//  sw_b_in   in   1  raw switch B, asynchronous to clk, may bounce
//  a         out  1  debounced level of switch A (feeds gate block input a)
//  b         out  1  debounced level of switch B (feeds gate block input b)
//  a_rise    out  1  one-cycle pulse, a went 0->1 this cycle
//  a_fall    out  1  one-cycle pulse, a went 1->0 this cycle
//  b_rise    out  1  one-cycle pulse, b went 0->1
//  b_fall    out  1  one-cycle pulse, b went 1->0
//  settled   out  1  1 when both channels are in STABLE (no pending change)
// BEHAVIOUR
//  - Reset values:
//    - sync flops, a, b = 0; all pulses = 0; counters = 0.
//    - Both channels are in STABLE, so settled = 1.
//  - Per channel:
//    - A 2-flop synchroniser produces sync2; no logic sits between the two flops.
//    - A 2-state FSM (STABLE, SETTLE) and a CNT_W-bit counter follow it.
//  - STABLE:
//    - sync2 == out: stay, cnt = 0.
//    - sync2 != out: go to SETTLE, cnt = 1.
//  - SETTLE:
//    - sync2 == out: glitch rejected. Return to STABLE, cnt = 0, out unchanged, no pulse.
//    - sync2 != out and cnt < DEBOUNCE_CYCLES-1: stay, cnt++.
//    - sync2 != out and cnt == DEBOUNCE_CYCLES-1: out <= sync2, pulse fires, go to STABLE, cnt = 0.
//  - Edge pulses:
//    - A pulse is registered and high for exactly the one cycle after out toggles, aligned with the new out value.
//    - rise/fall of the same channel are never both 1.
//  - Latency:
//    - A clean input change, first sampled at edge k, appears on out after edge k+1+DEBOUNCE_CYCLES.
//    - That is DEBOUNCE_CYCLES+2 edges in total.
//  - Bounce:
//    - Any return of sync2 to the old value before the count completes restarts debouncing from zero.
//    - out can never toggle twice within DEBOUNCE_CYCLES edges.
//  - Channels are fully independent. Simultaneous A and B changes are handled in parallel and can pulse in the same cycle.
//  - settled = (stateA == STABLE) && (stateB == STABLE), combinational from state registers.
//  - Reset mid-SETTLE:
//    - The pending change is discarded and outputs return to reset values immediately.
//    - After release, a held-high input re-debounces from scratch (full latency).
//  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is reachable.
//  - Unused FSM encodings recover to STABLE.
// STRUCTURE
//  - Shared package gate_io_pkg:
//    - deb_state_t enum {STABLE, SETTLE}.
//    - DEBOUNCE_CYCLES_DEFAULT = 16.
//    - DEBOUNCE_CYCLES_SIM = 4.
//  - Sub-module debounce_channel (sync + FSM + counter + rise/fall pulse), instantiated twice (A, B).
//  - The top level only wires the two instances and the settled AND.
// TESTING  (DEBOUNCE_CYCLES = 4, so latency = 6 edges)
//  1 Reset:
//    - Stimulus: hold rst_n=0 with sw_a_in=sw_b_in=1, then release.
//    - Response: a=b=0 and settled=1 during reset; a=b=1 exactly 6 edges after release, with a_rise=b_rise=1 for that one cycle.
//  2 Clean press:
//    - Stimulus: sw_a_in 0->1 at edge k.
//    - Response: a=1 after edge k+5, a_rise high one cycle, settled=0 from edge k+2 to k+5, b untouched.
//  3 Bounce:
//    - Stimulus: sw_a_in toggles 1,0,1,0 on successive edges, then holds 1.
//    - Response: a toggles only once, 6 edges after the final rising sample; exactly one a_rise.
//  4 Glitch:
//    - Stimulus: sw_b_in high for 3 edges, then back to 0.
//    - Response: b stays 0, no pulses, settled returns to 1.
//  5 Simultaneous:
//    - Stimulus: sw_a_in 1->0 and sw_b_in 0->1 at the same edge.
//    - Response: a_fall and b_rise pulse in the same cycle; a,b = 0,1.
//  6 Mid-settle reset:
//    - Stimulus: assert rst_n=0 2 edges into SETTLE, release with input still 1.
//    - Response: out=0 immediately; out=1 a full 6 edges after release.

Source files
------------

// File: rtl/gate_io_pkg.sv
// Shared types and constants for the gate-block input conditioning path.
package gate_io_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } deb_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, STABLE/SETTLE debounce FSM with
// hold counter, and registered rise/fall pulses aligned with the new level.
//
//   state  | meaning
//   STABLE | synchronised input matches level_o, counter idle at 0
//   SETTLE | input differs from level_o, counting consecutive agreeing edges
module debounce_channel
    import gate_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic stable_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sync2_q != level_q) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            SETTLE: begin
                if (sync2_q == level_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    // Count complete: commit the new level and flag the edge together.
                    state_d = STABLE;
                    cnt_d   = '0;
                    level_d = sync2_q;
                    rise_d  = sync2_q;
                    fall_d  = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign stable_o = (state_q == STABLE);

endmodule

// File: rtl/gate_input_debouncer.sv
// Conditions the two raw switch inputs of the logic-gate block: two independent
// debounce channels plus a combined settled flag.
module gate_input_debouncer
    import gate_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_a_in,
    input  logic sw_b_in,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic settled
);

    logic stable_a, stable_b;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_i     (sw_a_in),
        .level_o  (a),
        .rise_o   (a_rise),
        .fall_o   (a_fall),
        .stable_o (stable_a)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_i     (sw_b_in),
        .level_o  (b),
        .rise_o   (b_rise),
        .fall_o   (b_fall),
        .stable_o (stable_b)
    );

    assign settled = stable_a & stable_b;

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Directed bench for gate_input_debouncer with DEBOUNCE_CYCLES = 4 (6-edge latency).
module tb_gate_input_debouncer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_a_in = 1'b0;
    logic sw_b_in = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall, settled;

    int n_chk = 0;
    int n_err = 0;

    gate_input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_a_in (sw_a_in),
        .sw_b_in (sw_b_in),
        .a       (a),
        .b       (b),
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall),
        .settled (settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int rises, first_hi, pulses, hi_seen, unsettled;

        // 1: reset with both inputs high
        sw_a_in = 1'b1;
        sw_b_in = 1'b1;
        step(3);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_settled", settled, 1);
        chk("rst_pulse", {a_rise, a_fall, b_rise, b_fall}, 0);
        rst_n = 1'b1;
        step(5);
        chk("rel_a_early", a, 0);
        chk("rel_settled_low", settled, 0);
        step(1);
        chk("rel_a", a, 1);
        chk("rel_b", b, 1);
        chk("rel_rises", {a_rise, b_rise}, 3);
        chk("rel_settled", settled, 1);
        step(1);
        chk("rel_rise_gone", {a_rise, b_rise}, 0);

        // 2: clean press on A
        sw_a_in = 1'b0;
        step(5);
        chk("a_fall_pulse", a_fall, 0);
        step(1);
        chk("a_fall_pulse", a_fall, 1);
        chk("a_fall_rise_excl", a_rise, 0);
        step(2);
        sw_a_in = 1'b1;
        step(2);
        chk("press_settled_k1", settled, 1);
        step(1);
        chk("press_settled_k2", settled, 0);
        step(2);
        chk("press_a_k4", a, 0);
        chk("press_settled_k4", settled, 0);
        step(1);
        chk("press_a_k5", a, 1);
        chk("press_rise", a_rise, 1);
        chk("press_b", b, 1);
        chk("press_settled_k5", settled, 1);
        step(1);
        chk("press_rise_once", a_rise, 0);

        // 3: bounce on A (bring A low first)
        sw_a_in = 1'b0;
        step(8);
        chk("bounce_pre_a", a, 0);
        rises = 0;
        first_hi = 0;
        for (int i = 1; i <= 14; i++) begin
            sw_a_in = (i <= 4) ? ((i % 2) == 1) : 1'b1;
            step(1);
            if (a_rise) rises++;
            if (a && first_hi == 0) first_hi = i;
        end
        chk("bounce_edge", first_hi, 10);
        chk("bounce_rises", rises, 1);
        chk("bounce_a", a, 1);

        // 4: 3-edge glitch on B (bring B low first)
        sw_b_in = 1'b0;
        step(8);
        chk("glitch_pre_b", b, 0);
        pulses = 0;
        hi_seen = 0;
        unsettled = 0;
        for (int i = 1; i <= 10; i++) begin
            sw_b_in = (i <= 3);
            step(1);
            if (b_rise || b_fall) pulses++;
            if (b) hi_seen++;
            if (!settled) unsettled++;
        end
        chk("glitch_pulses", pulses, 0);
        chk("glitch_b_hi", hi_seen, 0);
        chk("glitch_unsettled", unsettled, 3);
        chk("glitch_settled", settled, 1);

        // 5: simultaneous A fall / B rise
        sw_a_in = 1'b0;
        sw_b_in = 1'b1;
        step(5);
        chk("simul_early", {a, b}, 2);
        step(1);
        chk("simul_ab", {a, b}, 1);
        chk("simul_pulses", {a_rise, a_fall, b_rise, b_fall}, 4'b0110);
        step(1);
        chk("simul_pulses_gone", {a_rise, a_fall, b_rise, b_fall}, 0);

        // 6: reset two edges into SETTLE on A, B currently high
        sw_a_in = 1'b1;
        step(4);
        chk("mid_settle_state", settled, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ab", {a, b}, 0);
        chk("mid_rst_settled", settled, 1);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("mid_rel_early", {a, b}, 0);
        step(1);
        chk("mid_rel_ab", {a, b}, 3);
        chk("mid_rel_rise", {a_rise, b_rise}, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
